menu_mode_fsm: RTL and testbench
================================

// Module: menu_mode_fsm
// PURPOSE
//   Parametrised menu/mode-selection controller between the keypad decoder and the game, LCD and music blocks.
//   Moves a mode cursor with PREV/NEXT keys (wrap-around, optional non-selectable splash slot 0).
//   Launches a game on ENTER and tracks MENU -> RUN -> RESULT.
//   Returns to the menu on BACK, on game completion plus acknowledge, or on timeout.
// PARAMETERS
//   NUM_MODES     4         number of cursor slots (>=2); MODE_W = $clog2(NUM_MODES) derived
//   SPLASH        1         1: slot 0 is a title splash, never launchable; 0: all slots launchable
//   DEFAULT_MODE  0         cursor value after reset (< NUM_MODES)
//   KEY_W         5         keypad code width
//   KEY_PREV      5'b00100  code for cursor-previous
//   KEY_NEXT      5'b00110  code for cursor-next
//   KEY_ENTER     5'b00101  code for launch / acknowledge
//   KEY_BACK      5'b00111  code for abort / return
//   TIMEOUT_CYC   40000000  RESULT auto-return delay in clk cycles (MENU_TIMEOUT_EN only)
// PORTS
//   clk          in   1       system clock
//   reset        in   1       asynchronous, active-high reset
//   key_code     in   KEY_W   decoded keypad code, sampled only when key_valid=1
//   key_valid    in   1       one-cycle strobe per key press
//   game_done    in   1       one-cycle strobe from game engine: round finished
//   mode_sel     out  MODE_W  current cursor / locked game mode
//   in_game      out  1       1 in RUN or RESULT (LCD game screen select)
//   show_result  out  1       1 in RESULT only
//   start_pulse  out  1       one-cycle strobe: game launched with mode_sel
//   abort_pulse  out  1       one-cycle strobe: game aborted by BACK
// BEHAVIOUR
//   Reset: state=MENU, mode_sel=DEFAULT_MODE, in_game=0, show_result=0, start_pulse=0, abort_pulse=0.
//   All outputs are registered. A key or done event at edge N is reflected at edge N+1 (latency 1).
//   A key_valid with an unlisted code does nothing. key_code is ignored while key_valid=0.
//   FSM states: MENU, RUN, RESULT.
//   MENU, NEXT: cursor+1; NUM_MODES-1 wraps to (SPLASH?1:0); with SPLASH, 0 -> 1.
//   MENU, PREV: cursor-1; (SPLASH?1:0) wraps to NUM_MODES-1; with SPLASH, 0 -> NUM_MODES-1.
//   MENU, ENTER: if cursor is launchable (not splash 0) -> RUN, start_pulse=1 for 1 cycle. Otherwise ignored.
//   MENU, BACK: ignored. game_done in MENU: ignored.
//   RUN: mode_sel is frozen. PREV/NEXT/ENTER are ignored.
//   RUN, game_done -> RESULT. RUN, BACK -> MENU, abort_pulse=1 for 1 cycle.
//   RUN, game_done and BACK in the same cycle: game_done wins -> RESULT, no abort_pulse.
//   RESULT: ENTER or BACK -> MENU. Cursor keeps the played mode. PREV/NEXT and game_done are ignored.
//   Reset asserted mid-game: immediate return to the reset values. No pulses are emitted.
//   start_pulse and abort_pulse are never high in the same cycle. Each is exactly 1 cycle wide.
// CONFIGURATION
//   MENU_TIMEOUT_EN defined:
//     A counter of width $clog2(TIMEOUT_CYC+1) clears on RESULT entry and on any key_valid in RESULT.
//     When the count reaches TIMEOUT_CYC-1, the FSM goes RESULT -> MENU on the next edge.
//     A key on the same edge takes precedence; the destination is the same.
//     The counter is held at 0 outside RESULT.
//   MENU_TIMEOUT_EN undefined: no counter logic; RESULT is left only by ENTER or BACK.
// TESTING (NUM_MODES=4, SPLASH=1, DEFAULT_MODE=0 unless noted)
//   Reset, then NEXT x4 -> mode_sel 1,2,3,1. Then PREV x2 -> 3,2. in_game stays 0.
//   From reset, ENTER at cursor 0 -> no start_pulse, state MENU. Then NEXT, ENTER -> start_pulse 1 cycle, mode_sel=1, in_game=1.
//   In RUN: NEXT/PREV -> mode_sel unchanged. game_done -> show_result=1. ENTER -> in_game=0, mode_sel=1.
//   In RUN: game_done and BACK on the same edge -> show_result=1, abort_pulse stays 0.
//   Assert reset mid-RUN with mode 3 -> all outputs return to reset values asynchronously, mode_sel=0.
//   MENU_TIMEOUT_EN, TIMEOUT_CYC=16: game_done, key at cycle 10, idle -> MENU exactly 16 cycles after the key.
//     Undefined build: stays in RESULT for 1000 cycles.

Source files
------------

// File: rtl/menu_mode_fsm.sv
// Menu/mode-selection controller: cursor over NUM_MODES slots, launches a game
// on ENTER and tracks MENU -> RUN -> RESULT. All outputs are registered.
// Optional build macro MENU_TIMEOUT_EN adds an auto-return from RESULT after
// TIMEOUT_CYC idle cycles; without it RESULT is left only by ENTER or BACK.
module menu_mode_fsm #(
  parameter int unsigned     NUM_MODES    = 4,
  parameter int unsigned     SPLASH       = 1,
  parameter int unsigned     DEFAULT_MODE = 0,
  parameter int unsigned     KEY_W        = 5,
  parameter logic [KEY_W-1:0] KEY_PREV    = 5'b00100,
  parameter logic [KEY_W-1:0] KEY_NEXT    = 5'b00110,
  parameter logic [KEY_W-1:0] KEY_ENTER   = 5'b00101,
  parameter logic [KEY_W-1:0] KEY_BACK    = 5'b00111,
  parameter int unsigned     TIMEOUT_CYC  = 40000000,
  localparam int unsigned    MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [KEY_W-1:0]  key_code_i,
  input  logic              key_valid_i,
  input  logic              game_done_i,
  output logic [MODE_W-1:0] mode_sel_o,
  output logic              in_game_o,
  output logic              show_result_o,
  output logic              start_pulse_o,
  output logic              abort_pulse_o
);

  typedef enum logic [1:0] {StMenu, StRun, StResult} state_e;

  // Lowest and highest cursor values reachable by wrap-around.
  localparam logic [MODE_W-1:0] FirstSel = (SPLASH != 0) ? MODE_W'(1) : '0;
  localparam logic [MODE_W-1:0] LastSel  = MODE_W'(NUM_MODES - 1);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              timeout;

  logic key_prev, key_next, key_enter, key_back;
  assign key_prev  = key_valid_i && (key_code_i == KEY_PREV);
  assign key_next  = key_valid_i && (key_code_i == KEY_NEXT);
  assign key_enter = key_valid_i && (key_code_i == KEY_ENTER);
  assign key_back  = key_valid_i && (key_code_i == KEY_BACK);

`ifdef MENU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StResult) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Idle counter: runs only while staying in RESULT with no key activity.
  always_comb begin
    cnt_d = '0;
    if (state_q == StResult && state_d == StResult && !key_valid_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, cursor and pulse decode.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      StMenu: begin
        if (key_next) begin
          mode_d = (mode_q == LastSel) ? FirstSel : mode_q + 1'b1;
        end else if (key_prev) begin
          // Splash slot 0 also wraps back to the last slot.
          mode_d = (mode_q == FirstSel || mode_q == '0) ? LastSel : mode_q - 1'b1;
        end else if (key_enter && !(SPLASH != 0 && mode_q == '0)) begin
          state_d = StRun;
          start_d = 1'b1;
        end
      end
      StRun: begin
        // game_done has priority over a simultaneous BACK.
        if (game_done_i) begin
          state_d = StResult;
        end else if (key_back) begin
          state_d = StMenu;
          abort_d = 1'b1;
        end
      end
      StResult: begin
        if (key_enter || key_back || timeout) begin
          state_d = StMenu;
        end
      end
      default: state_d = StMenu;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StMenu;
      mode_q  <= MODE_W'(DEFAULT_MODE);
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  assign mode_sel_o    = mode_q;
  assign in_game_o     = (state_q == StRun) || (state_q == StResult);
  assign show_result_o = (state_q == StResult);
  assign start_pulse_o = start_q;
  assign abort_pulse_o = abort_q;

endmodule

// File: tb/tb_menu_mode_fsm.sv
// Scoreboard bench for menu_mode_fsm (NUM_MODES=4, SPLASH=1, DEFAULT_MODE=0).
// Observed vector is {mode_sel, in_game, show_result, start_pulse, abort_pulse}.
module tb_menu_mode_fsm;

  localparam logic [4:0] KPrev  = 5'b00100;
  localparam logic [4:0] KNext  = 5'b00110;
  localparam logic [4:0] KEnter = 5'b00101;
  localparam logic [4:0] KBack  = 5'b00111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       game_done = 1'b0;
  logic [1:0] mode_sel;
  logic       in_game, show_result, start_pulse, abort_pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  menu_mode_fsm #(
    .NUM_MODES   (4),
    .SPLASH      (1),
    .DEFAULT_MODE(0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .key_code_i   (key_code),
    .key_valid_i  (key_valid),
    .game_done_i  (game_done),
    .mode_sel_o   (mode_sel),
    .in_game_o    (in_game),
    .show_result_o(show_result),
    .start_pulse_o(start_pulse),
    .abort_pulse_o(abort_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input int m, input bit g, input bit r, input bit s,
                                    input bit a);
    ex = {2'(m), g, r, s, a};
  endfunction

  function automatic logic [5:0] obs();
    obs = {mode_sel, in_game, show_result, start_pulse, abort_pulse};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input bit kv, input logic [4:0] code, input bit done,
                      input logic [5:0] want);
    @(negedge clk);
    key_valid = kv;
    key_code  = code;
    game_done = done;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_eq(tag_q.pop_front(), obs(), exp_q.pop_front());
    key_valid = 1'b0;
    game_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    tag_q.push_back("reset");
    #1;
    check_eq(tag_q.pop_front(), obs(), exp_q.pop_front());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Cursor wrap with splash slot skipped.
    step("next1", 1, KNext, 0, ex(1, 0, 0, 0, 0));
    step("next2", 1, KNext, 0, ex(2, 0, 0, 0, 0));
    step("next3", 1, KNext, 0, ex(3, 0, 0, 0, 0));
    step("next_wrap", 1, KNext, 0, ex(1, 0, 0, 0, 0));
    step("prev_wrap", 1, KPrev, 0, ex(3, 0, 0, 0, 0));
    step("prev2", 1, KPrev, 0, ex(2, 0, 0, 0, 0));
    step("bad_code", 1, 5'b00000, 0, ex(2, 0, 0, 0, 0));
    step("no_valid", 0, KNext, 0, ex(2, 0, 0, 0, 0));

    // Splash slot cannot be launched; BACK/game_done ignored in MENU.
    do_reset();
    step("enter_splash", 1, KEnter, 0, ex(0, 0, 0, 0, 0));
    step("back_menu", 1, KBack, 0, ex(0, 0, 0, 0, 0));
    step("done_menu", 0, 5'd0, 1, ex(0, 0, 0, 0, 0));
    step("prev_splash", 1, KPrev, 0, ex(3, 0, 0, 0, 0));
    do_reset();
    step("next_splash", 1, KNext, 0, ex(1, 0, 0, 0, 0));
    step("launch", 1, KEnter, 0, ex(1, 1, 0, 1, 0));
    step("start_1cyc", 0, 5'd0, 0, ex(1, 1, 0, 0, 0));

    // RUN freezes the cursor; RESULT keeps the played mode.
    step("run_next", 1, KNext, 0, ex(1, 1, 0, 0, 0));
    step("run_prev", 1, KPrev, 0, ex(1, 1, 0, 0, 0));
    step("run_enter", 1, KEnter, 0, ex(1, 1, 0, 0, 0));
    step("run_done", 0, 5'd0, 1, ex(1, 1, 1, 0, 0));
    step("res_next", 1, KNext, 0, ex(1, 1, 1, 0, 0));
    step("res_done", 0, 5'd0, 1, ex(1, 1, 1, 0, 0));
    step("res_enter", 1, KEnter, 0, ex(1, 0, 0, 0, 0));

    // Abort from RUN.
    step("prev_to3", 1, KPrev, 0, ex(3, 0, 0, 0, 0));
    step("launch3", 1, KEnter, 0, ex(3, 1, 0, 1, 0));
    step("abort", 1, KBack, 0, ex(3, 0, 0, 0, 1));
    step("abort_1cyc", 0, 5'd0, 0, ex(3, 0, 0, 0, 0));

    // game_done beats a simultaneous BACK.
    step("launch3b", 1, KEnter, 0, ex(3, 1, 0, 1, 0));
    step("done_back", 1, KBack, 1, ex(3, 1, 1, 0, 0));
    step("res_back", 1, KBack, 0, ex(3, 0, 0, 0, 0));

    // RESULT dwell: timeout build returns 16 cycles after the last key.
    step("launch3c", 1, KEnter, 0, ex(3, 1, 0, 1, 0));
    step("done_c", 0, 5'd0, 1, ex(3, 1, 1, 0, 0));
    for (int i = 0; i < 9; i++) step("res_idle", 0, 5'd0, 0, ex(3, 1, 1, 0, 0));
    step("res_key", 1, KNext, 0, ex(3, 1, 1, 0, 0));
`ifdef MENU_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      if (i < 15) step("tmo_wait", 0, 5'd0, 0, ex(3, 1, 1, 0, 0));
      else        step("tmo_fire", 0, 5'd0, 0, ex(3, 0, 0, 0, 0));
    end
`else
    for (int i = 0; i < 1000; i++) step("res_hold", 0, 5'd0, 0, ex(3, 1, 1, 0, 0));
    step("res_back2", 1, KBack, 0, ex(3, 0, 0, 0, 0));
`endif

    // Asynchronous reset in the middle of a game.
    step("launch3d", 1, KEnter, 0, ex(3, 1, 0, 1, 0));
    step("run3d", 0, 5'd0, 0, ex(3, 1, 0, 0, 0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    tag_q.push_back("async_reset");
    #1;
    check_eq(tag_q.pop_front(), obs(), exp_q.pop_front());
    @(posedge clk);
    #1;
    check_eq("reset_hold", obs(), ex(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 0, 5'd0, 0, ex(0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
